// File: rtl/jstk_pkg.sv
// Shared joystick definitions: direction codes, sample classes, thresholds
// and the move sequencer state encoding.
package jstk_pkg;

    localparam logic [1:0] DIR_UP    = 2'd0;
    localparam logic [1:0] DIR_DOWN  = 2'd1;
    localparam logic [1:0] DIR_RIGHT = 2'd2;
    localparam logic [1:0] DIR_LEFT  = 2'd3;

    // Class codes 0..3 are the directions themselves.
    localparam logic [2:0] CLS_NEUTRAL = 3'd4;
    localparam logic [2:0] CLS_DIAG    = 3'd5;
    localparam logic [2:0] LAST_NONE   = 3'd7;

    localparam int DEF_LO_TH = 384;
    localparam int DEF_HI_TH = 640;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_EVAL,
        S_ISSUE
    } state_t;

endpackage

// File: rtl/jstk_dir_classify.sv
// Combinational X/Y sample classifier: direction code, NEUTRAL or DIAG.
module jstk_dir_classify
    import jstk_pkg::*;
(
    input  logic [9:0] xPos,
    input  logic [9:0] yPos,
    input  logic [9:0] loTh,
    input  logic [9:0] hiTh,
    output logic [2:0] cls
);

    logic xMid, xHigh, xLow, yMid, yHigh, yLow;

    assign xMid  = (xPos >= loTh) && (xPos <= hiTh);
    assign xHigh = xPos > hiTh;
    assign xLow  = xPos < loTh;
    assign yMid  = (yPos >= loTh) && (yPos <= hiTh);
    assign yHigh = yPos > hiTh;
    assign yLow  = yPos < loTh;

    always_comb begin
        cls = CLS_DIAG;
        if (xMid && yMid)       cls = CLS_NEUTRAL;
        else if (xMid && yHigh) cls = {1'b0, DIR_UP};
        else if (xMid && yLow)  cls = {1'b0, DIR_DOWN};
        else if (xHigh && yMid) cls = {1'b0, DIR_RIGHT};
        else if (xLow && yMid)  cls = {1'b0, DIR_LEFT};
    end

endmodule

// File: rtl/jstk_move_sequencer.sv
// Polls the PmodJSTK periodically and turns confirmed, re-armed stick
// deflections into one-shot move commands with a valid/ready handshake.
module jstk_move_sequencer
    import jstk_pkg::*;
#(
    parameter int POLL_DIV = 20000000,
    parameter int TIMEOUT  = 65535,
    parameter int LO_TH    = DEF_LO_TH,
    parameter int HI_TH    = DEF_HI_TH,
    parameter int CONFIRM  = 2
) (
    input  logic       clk,
    input  logic       rst,
    output logic       xfer_start,
    input  logic       xfer_done,
    input  logic [9:0] x_pos,
    input  logic [9:0] y_pos,
    output logic       move_valid,
    output logic [1:0] move_dir,
    input  logic       move_ready,
    output logic       armed,
    output logic       timeout_err
);

    localparam int PW = (POLL_DIV > 1) ? $clog2(POLL_DIV) : 1;
    localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [PW-1:0] POLL_LAST = PW'(POLL_DIV - 1);
    localparam logic [TW-1:0] WAIT_LAST = TW'(TIMEOUT);
    localparam logic [2:0]    CONF_REQ  = 3'(CONFIRM);
    localparam logic [9:0]    LO_V      = 10'(LO_TH);
    localparam logic [9:0]    HI_V      = 10'(HI_TH);

    state_t        state, stateNext;
    logic [PW-1:0] pollCnt;
    logic [TW-1:0] waitCnt;
    logic [9:0]    xLat, yLat;
    logic [2:0]    cls, conf, confNext, confInc, lastDir, lastDirNext;
    logic [1:0]    moveDirNext;
    logic          armedNext, tick;

    assign tick       = (pollCnt == POLL_LAST);
    assign move_valid = (state == S_ISSUE);

    jstk_dir_classify u_classify (
        .xPos (xLat),
        .yPos (yLat),
        .loTh (LO_V),
        .hiTh (HI_V),
        .cls  (cls)
    );

    // Candidate confirm count if the current sample is a directional repeat.
    assign confInc = (cls == lastDir) ? ((conf == 3'd7) ? 3'd7 : conf + 3'd1) : 3'd1;

    always_comb begin
        stateNext   = state;
        confNext    = conf;
        lastDirNext = lastDir;
        armedNext   = armed;
        moveDirNext = move_dir;
        xfer_start  = 1'b0;
        timeout_err = 1'b0;
        case (state)
            S_IDLE: if (tick) stateNext = S_REQ;
            S_REQ: begin
                xfer_start = 1'b1;
                stateNext  = S_WAIT;
            end
            S_WAIT: begin
                if (xfer_done) begin
                    stateNext = S_EVAL;
                end else if (waitCnt == WAIT_LAST) begin
                    timeout_err = 1'b1;
                    confNext    = 3'd0;
                    stateNext   = S_IDLE;
                end
            end
            S_EVAL: begin
                stateNext = S_IDLE;
                if (cls == CLS_NEUTRAL) begin
                    armedNext   = 1'b1;
                    confNext    = 3'd0;
                    lastDirNext = LAST_NONE;
                end else if (cls == CLS_DIAG) begin
                    confNext    = 3'd0;
                    lastDirNext = LAST_NONE;
                end else if (armed) begin
                    lastDirNext = cls;
                    confNext    = confInc;
                    if (confInc >= CONF_REQ) begin
                        moveDirNext = cls[1:0];
                        armedNext   = 1'b0;
                        confNext    = 3'd0;
                        stateNext   = S_ISSUE;
                    end
                end
            end
            S_ISSUE: if (move_ready) stateNext = S_IDLE;
            default: stateNext = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            pollCnt  <= '0;
            waitCnt  <= '0;
            xLat     <= '0;
            yLat     <= '0;
            conf     <= 3'd0;
            lastDir  <= LAST_NONE;
            armed    <= 1'b1;
            move_dir <= DIR_UP;
        end else begin
            state    <= stateNext;
            pollCnt  <= tick ? '0 : pollCnt + PW'(1);
            if (state == S_REQ)       waitCnt <= '0;
            else if (state == S_WAIT) waitCnt <= waitCnt + TW'(1);
            if (state == S_WAIT && xfer_done) begin
                xLat <= x_pos;
                yLat <= y_pos;
            end
            conf     <= confNext;
            lastDir  <= lastDirNext;
            armed    <= armedNext;
            move_dir <= moveDirNext;
        end
    end

endmodule

// File: tb/tb_jstk_move_sequencer.sv
// Directed bench for jstk_move_sequencer with a scripted joystick responder.
module tb_jstk_move_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       xfer_start;
    logic       xfer_done;
    logic [9:0] x_pos;
    logic [9:0] y_pos;
    logic       move_valid;
    logic [1:0] move_dir;
    logic       move_ready;
    logic       armed;
    logic       timeout_err;

    int asserts = 0;
    int fails = 0;
    int moveCount = 0;
    int xferCount = 0;
    bit prevMv = 1'b0;

    jstk_move_sequencer #(
        .POLL_DIV (16),
        .TIMEOUT  (20),
        .LO_TH    (384),
        .HI_TH    (640),
        .CONFIRM  (2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .xfer_start  (xfer_start),
        .xfer_done   (xfer_done),
        .x_pos       (x_pos),
        .y_pos       (y_pos),
        .move_valid  (move_valid),
        .move_dir    (move_dir),
        .move_ready  (move_ready),
        .armed       (armed),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (move_valid && !prevMv) moveCount++;
        prevMv = move_valid;
        if (xfer_start) xferCount++;
    end

    // Answer the next transfer request; returns at the first cycle where a move could be visible.
    task automatic do_poll(input logic [9:0] x, input logic [9:0] y);
        int n = 0;
        while (!xfer_start && n < 40) begin
            @(negedge clk);
            n++;
        end
        asserts++;
        if (xfer_start !== 1'b1) begin
            fails++;
            $display("FAIL poll_req: xfer_start=%b after %0d cycles, want 1", xfer_start, n);
        end
        @(negedge clk);
        xfer_done = 1'b1;
        x_pos = x;
        y_pos = y;
        @(negedge clk);
        xfer_done = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        xfer_done = 1'b0;
        x_pos = '0;
        y_pos = '0;
        move_ready = 1'b0;
        repeat (3) @(negedge clk);
        asserts++;
        if ({xfer_start, move_valid, move_dir, timeout_err} !== 5'b0) begin
            fails++;
            $display("FAIL reset_outs: start/valid/dir/terr=%b want 00000",
                     {xfer_start, move_valid, move_dir, timeout_err});
        end
        asserts++;
        if (armed !== 1'b1) begin
            fails++;
            $display("FAIL reset_armed: got %b want 1", armed);
        end
        rst = 1'b0;
    endtask

    task automatic test_basic_move;
        int m0;
        move_ready = 1'b1;
        m0 = moveCount;
        do_poll(10'd512, 10'd900);
        asserts++;
        if (move_valid !== 1'b0) begin
            fails++;
            $display("FAIL basic_first_sample: move_valid=%b want 0", move_valid);
        end
        do_poll(10'd512, 10'd900);
        asserts++;
        if (move_valid !== 1'b1 || move_dir !== 2'd0) begin
            fails++;
            $display("FAIL basic_issue: valid=%b dir=%0d want 1/0", move_valid, move_dir);
        end
        @(negedge clk);
        asserts++;
        if (move_valid !== 1'b0 || armed !== 1'b0) begin
            fails++;
            $display("FAIL basic_after: valid=%b armed=%b want 0/0", move_valid, armed);
        end
        asserts++;
        if (moveCount - m0 !== 1) begin
            fails++;
            $display("FAIL basic_count: moves=%0d want 1", moveCount - m0);
        end
    endtask

    task automatic test_rearm;
        int m0;
        m0 = moveCount;
        repeat (5) do_poll(10'd512, 10'd900);
        @(negedge clk);
        asserts++;
        if (moveCount - m0 !== 0 || armed !== 1'b0) begin
            fails++;
            $display("FAIL rearm_held: moves=%0d armed=%b want 0/0", moveCount - m0, armed);
        end
        do_poll(10'd512, 10'd512);
        asserts++;
        if (armed !== 1'b1) begin
            fails++;
            $display("FAIL rearm_neutral: armed=%b want 1", armed);
        end
        do_poll(10'd512, 10'd100);
        do_poll(10'd512, 10'd100);
        asserts++;
        if (move_valid !== 1'b1 || move_dir !== 2'd1) begin
            fails++;
            $display("FAIL rearm_down: valid=%b dir=%0d want 1/1", move_valid, move_dir);
        end
        @(negedge clk);
        asserts++;
        if (moveCount - m0 !== 1) begin
            fails++;
            $display("FAIL rearm_count: moves=%0d want 1", moveCount - m0);
        end
    endtask

    task automatic test_confirm_reset;
        int m0;
        do_poll(10'd512, 10'd512);
        m0 = moveCount;
        do_poll(10'd900, 10'd512);
        do_poll(10'd100, 10'd512);
        asserts++;
        if (move_valid !== 1'b0) begin
            fails++;
            $display("FAIL confirm_switch: move_valid=%b want 0", move_valid);
        end
        // A second left sample completes the pair only if the switch restarted the count at 1.
        do_poll(10'd100, 10'd512);
        asserts++;
        if (move_valid !== 1'b1 || move_dir !== 2'd3) begin
            fails++;
            $display("FAIL confirm_restart: valid=%b dir=%0d want 1/3", move_valid, move_dir);
        end
        do_poll(10'd512, 10'd512);
        m0 = moveCount;
        do_poll(10'd900, 10'd512);
        do_poll(10'd900, 10'd900);
        do_poll(10'd900, 10'd512);
        @(negedge clk);
        asserts++;
        if (moveCount - m0 !== 0) begin
            fails++;
            $display("FAIL confirm_diag: moves=%0d want 0", moveCount - m0);
        end
        do_poll(10'd900, 10'd512);
        asserts++;
        if (move_valid !== 1'b1 || move_dir !== 2'd2) begin
            fails++;
            $display("FAIL confirm_after_diag: valid=%b dir=%0d want 1/2", move_valid, move_dir);
        end
    endtask

    task automatic test_boundaries;
        @(negedge clk);
        do_poll(10'd640, 10'd384);
        asserts++;
        if (armed !== 1'b1 || move_valid !== 1'b0) begin
            fails++;
            $display("FAIL bound_neutral: armed=%b valid=%b want 1/0", armed, move_valid);
        end
        do_poll(10'd641, 10'd512);
        do_poll(10'd641, 10'd512);
        asserts++;
        if (move_valid !== 1'b1 || move_dir !== 2'd2) begin
            fails++;
            $display("FAIL bound_right: valid=%b dir=%0d want 1/2", move_valid, move_dir);
        end
        do_poll(10'd640, 10'd384);
        do_poll(10'd383, 10'd512);
        do_poll(10'd383, 10'd512);
        asserts++;
        if (move_valid !== 1'b1 || move_dir !== 2'd3) begin
            fails++;
            $display("FAIL bound_left: valid=%b dir=%0d want 1/3", move_valid, move_dir);
        end
    endtask

    task automatic test_backpressure;
        int m0, x0;
        bit held = 1'b1;
        @(negedge clk);
        do_poll(10'd512, 10'd512);
        move_ready = 1'b0;
        m0 = moveCount;
        do_poll(10'd512, 10'd900);
        do_poll(10'd512, 10'd900);
        x0 = xferCount;
        for (int i = 0; i < 40; i++) begin
            if (move_valid !== 1'b1 || move_dir !== 2'd0) held = 1'b0;
            @(negedge clk);
        end
        asserts++;
        if (!held) begin
            fails++;
            $display("FAIL bp_hold: valid/dir not held, now valid=%b dir=%0d want 1/0", move_valid, move_dir);
        end
        asserts++;
        if (xferCount - x0 !== 0) begin
            fails++;
            $display("FAIL bp_ticks: xfer_start count=%0d want 0", xferCount - x0);
        end
        move_ready = 1'b1;
        @(negedge clk);
        asserts++;
        if (move_valid !== 1'b0) begin
            fails++;
            $display("FAIL bp_release: move_valid=%b want 0", move_valid);
        end
        asserts++;
        if (moveCount - m0 !== 1) begin
            fails++;
            $display("FAIL bp_count: moves=%0d want 1", moveCount - m0);
        end
    endtask

    task automatic test_timeout;
        int n;
        bit seen;
        move_ready = 1'b1;
        do_poll(10'd512, 10'd512);
        do_poll(10'd900, 10'd512);
        n = 0;
        while (!xfer_start && n < 40) begin
            @(negedge clk);
            n++;
        end
        asserts++;
        if (xfer_start !== 1'b1) begin
            fails++;
            $display("FAIL to_req: xfer_start=%b want 1", xfer_start);
        end
        n = 0;
        seen = 1'b0;
        while (n < 60 && !seen) begin
            @(negedge clk);
            n++;
            seen = timeout_err;
        end
        asserts++;
        if (n !== 21) begin
            fails++;
            $display("FAIL to_latency: timeout_err after %0d cycles from request, want 21", n);
        end
        @(negedge clk);
        asserts++;
        if (timeout_err !== 1'b0) begin
            fails++;
            $display("FAIL to_pulse: timeout_err=%b want 0", timeout_err);
        end
        // The pre-timeout right sample must not count toward the next one.
        do_poll(10'd900, 10'd512);
        asserts++;
        if (move_valid !== 1'b0) begin
            fails++;
            $display("FAIL to_conf_clear: move_valid=%b want 0", move_valid);
        end
        do_poll(10'd900, 10'd512);
        asserts++;
        if (move_valid !== 1'b1 || move_dir !== 2'd2) begin
            fails++;
            $display("FAIL to_recover: valid=%b dir=%0d want 1/2", move_valid, move_dir);
        end
    endtask

    task automatic test_reset_in_issue;
        @(negedge clk);
        do_poll(10'd512, 10'd512);
        move_ready = 1'b0;
        do_poll(10'd512, 10'd100);
        do_poll(10'd512, 10'd100);
        asserts++;
        if (move_valid !== 1'b1) begin
            fails++;
            $display("FAIL rst_issue_pre: move_valid=%b want 1", move_valid);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        asserts++;
        if (move_valid !== 1'b0 || armed !== 1'b1 || move_dir !== 2'd0) begin
            fails++;
            $display("FAIL rst_issue: valid=%b armed=%b dir=%0d want 0/1/0", move_valid, armed, move_dir);
        end
        xfer_done = 1'b1;
        x_pos = 10'd512;
        y_pos = 10'd900;
        @(negedge clk);
        xfer_done = 1'b0;
        repeat (3) @(negedge clk);
        asserts++;
        if (move_valid !== 1'b0 || xfer_start !== 1'b0) begin
            fails++;
            $display("FAIL rst_late_done: valid=%b start=%b want 0/0", move_valid, xfer_start);
        end
    endtask

    initial begin
        test_reset();
        test_basic_move();
        test_rearm();
        test_confirm_reset();
        test_boundaries();
        test_backpressure();
        test_timeout();
        test_reset_in_issue();
        $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
        $finish;
    end

endmodule
